// File: rtl/program_loader_if.sv
// Byte-stream and program-memory write bundle between the boot pins and program_loader.
// slave = the loader; master = stream source and memory-side observer.
interface program_loader_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADD_WIDTH  = 7
);
   // Handshake: a byte transfers on a rising edge where byte_valid & byte_ready & ~load_start;
   // the source holds byte_in stable while byte_valid is high and not yet accepted.
   logic                  load_start;
   logic                  byte_valid;
   logic [DATA_WIDTH-1:0] byte_in;
   logic                  byte_ready;
   logic                  wrEn;
   logic [ADD_WIDTH-1:0]  writeAdd;
   logic [DATA_WIDTH-1:0] writeData;
   logic                  cpu_run;
   logic                  load_error;

   modport master (
      output load_start, byte_valid, byte_in,
      input  byte_ready, wrEn, writeAdd, writeData, cpu_run, load_error
   );

   modport slave (
      input  load_start, byte_valid, byte_in,
      output byte_ready, wrEn, writeAdd, writeData, cpu_run, load_error
   );
endinterface

// File: rtl/program_loader.sv
// Fills program memory from a length-prefixed byte stream, then releases the CPU via cpu_run.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
   parameter int DATA_WIDTH = 8,
   parameter int ADD_WIDTH  = 7
) (
   input  logic                clk,
   input  logic                rst_n,
   program_loader_if.slave     bus,
   output logic [2:0]          dbg_state
);
   // One extra bit so a full-depth image (length byte 0) is representable.
   localparam int               CNT_W     = ADD_WIDTH + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(2 ** ADD_WIDTH);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HEADER = 3'd1,
      DATA   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
      CHECK  = 3'd3,
`endif
      RUN    = 3'd4,
      ERROR  = 3'd5
   } state_e;

   state_e                state;
   logic [CNT_W-1:0]      cnt;
   logic [ADD_WIDTH-1:0]  addr;
   logic                  wr_en_q;
   logic [ADD_WIDTH-1:0]  write_add_q;
   logic [DATA_WIDTH-1:0] write_data_q;
   logic                  byte_ready_q;
   logic                  cpu_run_q;
   logic                  accept;

   assign accept = bus.byte_valid & byte_ready_q & ~bus.load_start;

`ifdef LOADER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] csum;
   logic                  load_error_q;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         addr         <= '0;
         wr_en_q      <= 1'b0;
         write_add_q  <= '0;
         write_data_q <= '0;
         byte_ready_q <= 1'b0;
         cpu_run_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum         <= '0;
         load_error_q <= 1'b0;
`endif
      end else begin
         wr_en_q <= 1'b0;
         if (bus.load_start) begin
            // Restart wins over everything, including a byte offered this cycle.
            state        <= HEADER;
            cnt          <= '0;
            addr         <= '0;
            byte_ready_q <= 1'b1;
            cpu_run_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum         <= '0;
            load_error_q <= 1'b0;
`endif
         end else begin
            unique case (state)
               IDLE: ;
               HEADER: begin
                  if (accept) begin
                     cnt   <= (bus.byte_in == '0) ? DEPTH_CNT : CNT_W'(bus.byte_in);
                     addr  <= '0;
                     state <= DATA;
                  end
               end
               DATA: begin
                  if (accept) begin
                     wr_en_q      <= 1'b1;
                     write_add_q  <= addr;
                     write_data_q <= bus.byte_in;
                     addr         <= addr + ADD_WIDTH'(1);
                     cnt          <= cnt - CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
                     csum         <= csum ^ bus.byte_in;
`endif
                     if (cnt == CNT_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                        state        <= CHECK;
`else
                        state        <= RUN;
                        byte_ready_q <= 1'b0;
`endif
                     end
                  end
               end
`ifdef LOADER_CHECKSUM_EN
               CHECK: begin
                  if (accept) begin
                     byte_ready_q <= 1'b0;
                     if (bus.byte_in == csum) begin
                        state     <= RUN;
                        cpu_run_q <= 1'b1;
                     end else begin
                        state        <= ERROR;
                        load_error_q <= 1'b1;
                     end
                  end
               end
`endif
               // Entered from DATA with cpu_run low, so it rises one cycle after the last write pulse.
               RUN:   cpu_run_q <= 1'b1;
               ERROR: ;
               default: begin
                  state        <= IDLE;
                  byte_ready_q <= 1'b0;
                  cpu_run_q    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.byte_ready = byte_ready_q;
   assign bus.wrEn       = wr_en_q;
   assign bus.writeAdd   = write_add_q;
   assign bus.writeData  = write_data_q;
   assign bus.cpu_run    = cpu_run_q;
`ifdef LOADER_CHECKSUM_EN
   assign bus.load_error = load_error_q;
`else
   assign bus.load_error = 1'b0;
`endif
   assign dbg_state      = state;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: reset, basic load, full depth with gaps, restart, checksum, reset in RUN.
module tb_program_loader;
   localparam int DW = 8;
   localparam int AW = 7;
   localparam int W  = DW + AW;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_HEADER = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_CHECK  = 3'd3;
   localparam logic [2:0] S_RUN    = 3'd4;
   localparam logic [2:0] S_ERROR  = 3'd5;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   program_loader_if #(.DATA_WIDTH(DW), .ADD_WIDTH(AW)) bus ();
   logic [2:0] dbg_state;

   program_loader #(.DATA_WIDTH(DW), .ADD_WIDTH(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // scoreboard
   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] got_q[$];

   always @(negedge clk)
      if (rst_n === 1'b1 && bus.wrEn === 1'b1)
         got_q.push_back({bus.writeAdd, bus.writeData});

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_writes(input string tag);
      int n;
      chk({tag, "_count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_wr%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      bus.byte_valid = 1'b1;
      bus.byte_in    = b;
      step();
      bus.byte_valid = 1'b0;
   endtask

   task automatic start();
      bus.load_start = 1'b1;
      step();
      bus.load_start = 1'b0;
   endtask

   task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_q.push_back({a, d});
   endtask

   initial begin
      bus.load_start = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_in    = '0;

      // reset with random inputs
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.load_start = 1'($urandom_range(0, 1));
         bus.byte_valid = 1'($urandom_range(0, 1));
         bus.byte_in    = 8'($urandom_range(0, 255));
         step();
      end
      chk("rst_state", dbg_state, S_IDLE);
      chk("rst_ready", bus.byte_ready, 1'b0);
      chk("rst_wren", bus.wrEn, 1'b0);
      chk("rst_addr", bus.writeAdd, 7'h00);
      chk("rst_data", bus.writeData, 8'h00);
      chk("rst_run", bus.cpu_run, 1'b0);
      chk("rst_err", bus.load_error, 1'b0);
      bus.load_start = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_in    = '0;
      rst_n = 1'b1;
      step();
      chk("idle_hold", dbg_state, S_IDLE);
      got_q.delete();

      // basic load, back-to-back
      start();
      chk("basic_hdr_state", dbg_state, S_HEADER);
      chk("basic_hdr_ready", bus.byte_ready, 1'b1);
      bus.byte_valid = 1'b1;
      bus.byte_in = 8'h04; step();
      chk("basic_data_state", dbg_state, S_DATA);
      chk("basic_hdr_nowr", bus.wrEn, 1'b0);
      bus.byte_in = 8'h11; step();
      bus.byte_in = 8'h22; step();
      bus.byte_in = 8'h33; step();
      bus.byte_in = 8'h44; step();
      bus.byte_valid = 1'b0;
      chk("basic_last_wren", bus.wrEn, 1'b1);
      chk("basic_last_addr", bus.writeAdd, 7'h03);
      chk("basic_last_data", bus.writeData, 8'h44);
      chk("basic_last_run", bus.cpu_run, 1'b0);
      chk("basic_last_ready", bus.byte_ready, 1'b0);
      step();
      chk("basic_run", bus.cpu_run, 1'b1);
      chk("basic_run_wren", bus.wrEn, 1'b0);
      chk("basic_run_state", dbg_state, S_RUN);
      expect_wr(7'h00, 8'h11);
      expect_wr(7'h01, 8'h22);
      expect_wr(7'h02, 8'h33);
      expect_wr(7'h03, 8'h44);
      check_writes("basic");

      // bytes offered in RUN are not taken
      bus.byte_valid = 1'b1;
      bus.byte_in = 8'h99;
      step();
      step();
      bus.byte_valid = 1'b0;
      chk("run_ignore_wren", bus.wrEn, 1'b0);
      chk("run_ignore_run", bus.cpu_run, 1'b1);
      check_writes("run_ignore");

      // full depth, byte_valid toggling
      start();
      send(8'h00);
      step();
      for (int i = 0; i < 128; i++) begin
         send(8'(i));
         expect_wr(7'(i), 8'(i));
         if (i != 127) step();
      end
      chk("full_last_wren", bus.wrEn, 1'b1);
      chk("full_last_addr", bus.writeAdd, 7'h7F);
      chk("full_last_data", bus.writeData, 8'h7F);
      chk("full_last_run", bus.cpu_run, 1'b0);
      step();
      chk("full_run", bus.cpu_run, 1'b1);
      step();
      step();
      check_writes("full");

      // restart mid-load
      start();
      send(8'h08);
      send(8'h01);
      send(8'h02);
      send(8'h03);
      bus.load_start = 1'b1;
      bus.byte_valid = 1'b1;
      bus.byte_in = 8'h55;
      step();
      bus.load_start = 1'b0;
      bus.byte_valid = 1'b0;
      chk("restart_wren", bus.wrEn, 1'b0);
      chk("restart_state", dbg_state, S_HEADER);
      chk("restart_ready", bus.byte_ready, 1'b1);
      chk("restart_run", bus.cpu_run, 1'b0);
      expect_wr(7'h00, 8'h01);
      expect_wr(7'h01, 8'h02);
      expect_wr(7'h02, 8'h03);

      // load_start together with the final data byte drops it
      send(8'h01);
      bus.load_start = 1'b1;
      bus.byte_valid = 1'b1;
      bus.byte_in = 8'h77;
      step();
      bus.load_start = 1'b0;
      bus.byte_valid = 1'b0;
      chk("final_drop_wren", bus.wrEn, 1'b0);
      chk("final_drop_state", dbg_state, S_HEADER);
      step();
      chk("final_drop_run", bus.cpu_run, 1'b0);

      send(8'h02);
      send(8'hAA);
      send(8'hBB);
      expect_wr(7'h00, 8'hAA);
      expect_wr(7'h01, 8'hBB);
`ifdef LOADER_CHECKSUM_EN
      chk("restart_check_state", dbg_state, S_CHECK);
      send(8'h11);
      chk("restart_check_run", bus.cpu_run, 1'b1);
`else
      step();
      chk("restart_done_run", bus.cpu_run, 1'b1);
`endif
      chk("restart_done_state", dbg_state, S_RUN);
      check_writes("restart");

`ifdef LOADER_CHECKSUM_EN
      // checksum pass and fail
      start();
      send(8'h02);
      send(8'h0F);
      send(8'hF0);
      chk("cs_check_state", dbg_state, S_CHECK);
      chk("cs_check_ready", bus.byte_ready, 1'b1);
      chk("cs_check_run", bus.cpu_run, 1'b0);
      send(8'hFF);
      chk("cs_ok_run", bus.cpu_run, 1'b1);
      chk("cs_ok_err", bus.load_error, 1'b0);
      chk("cs_ok_ready", bus.byte_ready, 1'b0);
      start();
      chk("cs_restart_run", bus.cpu_run, 1'b0);
      send(8'h02);
      send(8'h0F);
      send(8'hF0);
      send(8'hFE);
      chk("cs_bad_err", bus.load_error, 1'b1);
      chk("cs_bad_run", bus.cpu_run, 1'b0);
      chk("cs_bad_state", dbg_state, S_ERROR);
      expect_wr(7'h00, 8'h0F);
      expect_wr(7'h01, 8'hF0);
      expect_wr(7'h00, 8'h0F);
      expect_wr(7'h01, 8'hF0);
      check_writes("cs");
      start();
      chk("cs_err_clear", bus.load_error, 1'b0);
      send(8'h01);
      send(8'h3C);
      send(8'h3C);
      expect_wr(7'h00, 8'h3C);
      check_writes("cs_single");
`else
      chk("nocs_err_tied", bus.load_error, 1'b0);
`endif

      // reset while in RUN
      if (dbg_state != S_RUN) begin
         start();
         send(8'h01);
         send(8'h5A);
`ifdef LOADER_CHECKSUM_EN
         send(8'h5A);
`else
         step();
`endif
         got_q.delete();
      end
      chk("pre_rst_run", bus.cpu_run, 1'b1);
      rst_n = 1'b0;
      bus.load_start = 1'b1;
      step();
      bus.load_start = 1'b0;
      chk("rst_run_cpu", bus.cpu_run, 1'b0);
      chk("rst_run_state", dbg_state, S_IDLE);
      chk("rst_run_ready", bus.byte_ready, 1'b0);
      rst_n = 1'b1;
      step();
      chk("rst_run_idle", dbg_state, S_IDLE);
      chk("rst_run_cpu2", bus.cpu_run, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
